// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Optional sub-word support is selected with the DMEM_SUBWORD_EN macro.
package dmem_pkg;

  // Controller sequencing states; RMW states exist only with sub-word support.
  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdData,
    StWr,
`ifdef DMEM_SUBWORD_EN
    StRmwWait,
    StRmwData,
    StRmwWr,
`endif
    StResp
  } state_e;

  // RV32I load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Access size as encoded in funct3[1:0].
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Byte lanes within a word, and the offset bit selecting the upper halfword.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;
  localparam int unsigned HALF_SEL_BIT = 1;

  // True when the access size implied by funct3 does not fit the byte offset.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return ((funct3[1:0] == SIZE_H) && offset[0]) ||
           ((funct3[1:0] == SIZE_W) && (offset != OFF_B0));
  endfunction

endpackage

// File: rtl/dmem_controller_if.sv
// Core-request / response and RAM-port bundle of the load/store unit.
// slave: controller view; master: core plus RAM environment view.
interface dmem_controller_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              req_read;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, req_funct3, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, req_funct3, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational load extract/extend and sub-word store merge.
// Sub-word handling is built only with DMEM_SUBWORD_EN; otherwise pure word pass-through.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

`ifdef DMEM_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the RAM word.
  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (offset_i)
      OFF_B0: byte_sel = rdata_i[7:0];
      OFF_B1: byte_sel = rdata_i[15:8];
      OFF_B2: byte_sel = rdata_i[23:16];
      OFF_B3: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[HALF_SEL_BIT] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Sign- or zero-extend the selected lane according to funct3.
  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Overlay the store lane(s) onto the word read back from RAM.
  always_comb begin
    merge_data_o = rdata_i;
    case (funct3_i)
      F3_B: begin
        unique case (offset_i)
          OFF_B0: merge_data_o[7:0]   = wdata_i[7:0];
          OFF_B1: merge_data_o[15:8]  = wdata_i[7:0];
          OFF_B2: merge_data_o[23:16] = wdata_i[7:0];
          OFF_B3: merge_data_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (offset_i[HALF_SEL_BIT]) merge_data_o[31:16] = wdata_i[15:0];
        else                        merge_data_o[15:0]  = wdata_i[15:0];
      end
      default: merge_data_o = wdata_i;
    endcase
  end
`else
  logic unused_sel;

  assign load_data_o  = rdata_i;
  assign merge_data_o = wdata_i;
  assign unused_sel   = ^{funct3_i, offset_i};
`endif

endmodule

// File: rtl/dmem_controller.sv
// Load/store unit between the core data port and a synchronous word RAM.
// Define DMEM_SUBWORD_EN for byte/halfword accesses (RMW stores, misalignment errors).
module dmem_controller
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  dmem_controller_if.slave bus
);

  state_e              state_q;
  logic [2:0]          funct3_q;
  logic [1:0]          offset_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;

  logic                accept;
  logic                req_err;
  logic [31:0]         load_data;
  logic [31:0]         merge_data;

  dmem_lane_align u_lane_align (
    .funct3_i     (funct3_q),
    .offset_i     (offset_q),
    .rdata_i      (bus.ram_dout),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

`ifdef DMEM_SUBWORD_EN
  logic legal;
`endif

  // Decode the incoming request: acceptance and error classification.
  always_comb begin
    accept = (state_q == StIdle) && (bus.req_read || bus.req_write);
`ifdef DMEM_SUBWORD_EN
    // A simultaneous read+write is handled as a read, so read legality applies.
    if (bus.req_read) legal = bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else              legal = bus.req_funct3 inside {F3_B, F3_H, F3_W};
    req_err = !legal || misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    req_err = 1'b0;
`endif
  end

  // Sequencing FSM with registered response and RAM-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      funct3_q     <= '0;
      offset_q     <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            funct3_q <= bus.req_funct3;
            offset_q <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata;
            if (req_err) begin
              // No RAM access on the error path.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= StResp;
            end else begin
              ram_addr_q <= bus.req_addr[ADDR_W+1:2];
              if (bus.req_read) begin
                state_q <= StRdWait;
`ifdef DMEM_SUBWORD_EN
              end else if (bus.req_funct3 != F3_W) begin
                state_q <= StRmwWait;
`endif
              end else begin
                ram_we_q  <= 1'b1;
                ram_din_q <= bus.req_wdata;
                state_q   <= StWr;
              end
            end
          end
        end
        StRdWait: state_q <= StRdData;
        StRdData: begin
          resp_rdata_q <= load_data;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StWr: begin
          ram_we_q     <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
`ifdef DMEM_SUBWORD_EN
        StRmwWait: state_q <= StRmwData;
        StRmwData: begin
          ram_din_q <= merge_data;
          ram_we_q  <= 1'b1;
          state_q   <= StRmwWr;
        end
        StRmwWr: begin
          ram_we_q     <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
`endif
        StResp: begin
          resp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;

  // Address bits above the RAM window wrap and are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

`ifdef DMEM_SUBWORD_EN
  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
  logic unused_word_only;
  assign unused_word_only = ^{resp_err_q, merge_data};
`endif

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: directed table, reset corner cases,
// and randomized requests against a byte-level reference model.
module tb_dmem_controller;
  import dmem_pkg::*;

  localparam int unsigned ADDR_W = 9;
`ifdef DMEM_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_controller_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_controller #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM with a backdoor port for preloading.
  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[8:0]; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference: byte-addressed memory semantics; updates ref_mem for stores.
  // Latency counts negedges after the acceptance edge until resp_valid is seen.
  function automatic void model(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err, output int lat, output int we_at,
                                output logic [31:0] din);
    int idx  = int'((addr >> 2) % 512);
    int off  = int'(addr % 4);
    int size = 4;
    bit sgn  = 1'b0;
    logic [31:0] word = ref_mem[idx];
    logic [31:0] m;
    rdata = '0; err = 1'b0; lat = 0; we_at = 0; din = '0;
    if (SUBWORD) begin
      if (rd) begin
        case (f3)
          3'd0: begin size = 1; sgn = 1'b1; end
          3'd1: begin size = 2; sgn = 1'b1; end
          3'd2: size = 4;
          3'd4: size = 1;
          3'd5: size = 2;
          default: size = 0;
        endcase
      end else begin
        case (f3)
          3'd0: size = 1;
          3'd1: size = 2;
          3'd2: size = 4;
          default: size = 0;
        endcase
      end
      if (size == 0 || (off % size) != 0) begin
        err = 1'b1; lat = 1;
        return;
      end
    end else begin
      off = 0;
    end
    m = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (rd) begin
      rdata = (word >> (8 * off)) & m;
      if (sgn && rdata[8 * size - 1]) rdata = rdata | ~m;
      lat = 3;
    end else begin
      din = (word & ~(m << (8 * off))) | ((wdata << (8 * off)) & (m << (8 * off)));
      ref_mem[idx] = din;
      we_at = (size == 4) ? 1 : 3;
      lat = we_at + 1;
    end
  endfunction

  // Drive one request and observe the DUT until its response strobe.
  task automatic run_req(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit noise,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int we_cnt, output int we_at, output logic [31:0] we_din,
                         output logic [8:0] we_addr, output logic idle_ok);
    int w = 0;
    rdata = '0; err = 1'b0; lat = 0; we_cnt = 0; we_at = 0; we_din = '0; we_addr = '0;
    idle_ok = 1'b0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    bus.req_read = rd; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    if (noise) begin
      // Requests presented while busy must be ignored.
      bus.req_read = 1'b0; bus.req_write = 1'b1; bus.req_funct3 = 3'($urandom);
      bus.req_addr = $urandom; bus.req_wdata = $urandom;
    end else begin
      bus.req_read = 1'b0; bus.req_write = 1'b0;
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.ram_we === 1'b1) begin
        we_cnt++; we_at = i; we_din = bus.ram_din; we_addr = bus.ram_addr;
      end
      if (bus.resp_valid === 1'b1) begin
        lat = i; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
    bus.req_read = 1'b0; bus.req_write = 1'b0;
    @(negedge clk);
    idle_ok = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1);
  endtask

  task automatic exercise(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit noise,
                          input bit has_tbl, input logic [31:0] t_rdata, input logic t_err,
                          input int t_lat);
    logic [31:0] m_rdata, m_din, g_rdata, g_din;
    logic        m_err, g_err, g_idle;
    logic [8:0]  g_waddr;
    int          m_lat, m_we_at, g_lat, g_we_cnt, g_we_at;
    model(rd, f3, addr, wdata, m_rdata, m_err, m_lat, m_we_at, m_din);
    run_req(rd, wr, f3, addr, wdata, noise, g_rdata, g_err, g_lat, g_we_cnt, g_we_at, g_din,
            g_waddr, g_idle);
    if (has_tbl) begin
      chk({tag, " rdata"}, g_rdata, t_rdata);
      chk({tag, " err"}, 32'(g_err), 32'(t_err));
      chk({tag, " latency"}, g_lat, t_lat);
    end else begin
      chk({tag, " rdata"}, g_rdata, m_rdata);
      chk({tag, " err"}, 32'(g_err), 32'(m_err));
      chk({tag, " latency"}, g_lat, m_lat);
    end
    chk({tag, " we_count"}, g_we_cnt, (m_we_at != 0) ? 1 : 0);
    if (m_we_at != 0) begin
      chk({tag, " we_cycle"}, g_we_at, m_we_at);
      chk({tag, " ram_din"}, g_din, m_din);
      chk({tag, " ram_addr"}, 32'(g_waddr), (addr >> 2) % 512);
    end
    chk({tag, " idle_after_resp"}, 32'(g_idle), 32'd1);
  endtask

  // Reset asserted 'after' edges past acceptance of SB 0x10 (wdata 0x55).
  task automatic reset_mid(input string tag, input int after);
    logic        we_before;
    logic [31:0] exp_word;
    bd_write(4, 32'h80FF7F01);
    @(negedge clk);
    bus.req_read = 1'b0; bus.req_write = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1;
    bus.req_write = 1'b0;
    repeat (after) @(posedge clk);
    #1;
    we_before = bus.ram_we;
    chk({tag, " we_before_reset"}, 32'(we_before), (SUBWORD && after == 2) ? 32'd1 : 32'd0);
    rst = 1'b0;
    #1;
    chk({tag, " we_in_reset"}, 32'(bus.ram_we), 32'd0);
    chk({tag, " valid_in_reset"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, " ready_after_release"}, 32'(bus.req_ready), 32'd1);
    // Without sub-word support this is a word store that already wrote at E1.
    exp_word = SUBWORD ? 32'h80FF7F01 : 32'h55;
    chk({tag, " word4_after_reset"}, mem[4], exp_word);
    ref_mem[4] = exp_word;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] s_rdata;
    logic        s_err;
    int          s_lat;
    logic [31:0] w_rdata;
    int          w_lat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.req_read = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    #2 rst = 1'b0;
    #3;
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset resp_err", 32'(bus.resp_err), 32'd0);
    chk("reset ram_we", 32'(bus.ram_we), 32'd0);
    chk("reset ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("reset ram_din", bus.ram_din, 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 512; i++) bd_write(i, $urandom);
    bd_write(4, 32'h80FF7F01);
    @(negedge clk);
    rst = 1'b1;

    //         rd wr f3    addr   wdata         sub: rdata     err lat  word: rdata  lat
    tbl[0]  = '{1, 0, F3_W,  32'h10, 32'h0,        32'h80FF7F01, 0, 3, 32'h80FF7F01, 3};
    tbl[1]  = '{1, 0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 0, 3, 32'h80FF7F01, 3};
    tbl[2]  = '{1, 0, F3_BU, 32'h13, 32'h0,        32'h00000080, 0, 3, 32'h80FF7F01, 3};
    tbl[3]  = '{1, 0, F3_H,  32'h12, 32'h0,        32'hFFFF80FF, 0, 3, 32'h80FF7F01, 3};
    tbl[4]  = '{1, 0, F3_HU, 32'h10, 32'h0,        32'h00007F01, 0, 3, 32'h80FF7F01, 3};
    tbl[5]  = '{0, 1, F3_B,  32'h11, 32'h123456AA, 32'h0,        0, 4, 32'h0,        2};
    tbl[6]  = '{1, 0, F3_W,  32'h10, 32'h0,        32'h80FFAA01, 0, 3, 32'h123456AA, 3};
    tbl[7]  = '{1, 0, F3_W,  32'h12, 32'h0,        32'h0,        1, 1, 32'h123456AA, 3};
    tbl[8]  = '{0, 1, F3_H,  32'h11, 32'h0000BEEF, 32'h0,        1, 1, 32'h0,        2};
    tbl[9]  = '{1, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h80FFAA01, 0, 3, 32'h0000BEEF, 3};
    tbl[10] = '{1, 0, F3_W,  32'h10, 32'h0,        32'h80FFAA01, 0, 3, 32'h0000BEEF, 3};
    tbl[11] = '{1, 0, 3'd3,  32'h10, 32'h0,        32'h0,        1, 1, 32'h0000BEEF, 3};
    tbl[12] = '{0, 1, 3'd4,  32'h20, 32'h11111111, 32'h0,        1, 1, 32'h0,        2};
    tbl[13] = '{0, 1, F3_H,  32'h16, 32'h0000CAFE, 32'h0,        0, 4, 32'h0,        2};
    tbl[14] = '{1, 0, F3_H,  32'h16, 32'h0,        32'hFFFFCAFE, 0, 3, 32'h0000CAFE, 3};
    tbl[15] = '{1, 0, F3_BU, 32'h17, 32'h0,        32'h000000CA, 0, 3, 32'h0000CAFE, 3};

    for (int i = 0; i < 16; i++) begin
      exercise($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr,
               tbl[i].wdata, 1'b0, 1'b1,
               SUBWORD ? tbl[i].s_rdata : tbl[i].w_rdata,
               SUBWORD ? tbl[i].s_err : 1'b0,
               SUBWORD ? tbl[i].s_lat : tbl[i].w_lat);
    end
    chk("tbl word4 final", mem[4], SUBWORD ? 32'h80FFAA01 : 32'h0000BEEF);

    reset_mid("rst1", 1);
    reset_mid("rst2", 2);

    for (int n = 0; n < 300; n++) begin
      bit          rd, wr;
      int          k;
      logic [31:0] addr;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      k = $urandom_range(0, 8);
      addr = ($urandom & 32'hFFFF_F803) | ((k == 8) ? 32'h7FC : 32'(k) << 2);
      exercise($sformatf("rnd%0d", n), rd, wr, 3'($urandom), addr, $urandom,
               1'($urandom), 1'b0, '0, 1'b0, 0);
    end

    for (int i = 0; i < 9; i++) begin
      int idx = (i == 8) ? 511 : i;
      chk($sformatf("mem word %0d", idx), mem[idx], ref_mem[idx]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
